// File: rtl/coin_game_pkg.sv
// Shared definitions for the coin game: game state encoding, coin types and
// the default judging row.
package coin_game_pkg;

  typedef enum logic {
    ST_PLAY = 1'b0,
    ST_OVER = 1'b1
  } game_state_t;

  localparam logic COIN_1X1 = 1'b0;
  localparam logic COIN_2X1 = 1'b1;

  localparam int unsigned CATCH_Y_DEFAULT = 15;

  // Base points per lane fit in two bits (1 for 1x1, 2 for 2x1).
  localparam int unsigned BASE_PTS_W = 2;

endpackage

// File: rtl/lane_judge.sv
// Combinational judge for one coin lane: decides hit/miss at the catch row
// and the base points a hit is worth.
module lane_judge
  import coin_game_pkg::*;
#(
  parameter int unsigned X_W     = 3,
  parameter int unsigned Y_W     = 4,
  parameter int unsigned CATCH_Y = CATCH_Y_DEFAULT
) (
  input  logic [X_W-1:0]        player_x,
  input  logic [X_W-1:0]        coin_x,
  input  logic [Y_W-1:0]        coin_y,
  input  logic                  coin_type,
  input  logic                  coin_valid,
  output logic                  hit_c,
  output logic                  miss_c,
  output logic [BASE_PTS_W-1:0] pts_c
);

  logic         judged;
  logic         overlap;
  logic [X_W:0] right_col;

  always_comb begin
    judged    = coin_valid && (coin_y == Y_W'(CATCH_Y));
    // Right half of a 2x1 coin is computed one bit wider so column max does not wrap to 0.
    right_col = {1'b0, coin_x} + (X_W+1)'(1);
    overlap   = (player_x == coin_x) ||
                ((coin_type == COIN_2X1) && ({1'b0, player_x} == right_col));
    hit_c     = judged && overlap;
    miss_c    = judged && !overlap;
    pts_c     = '0;
    if (hit_c) begin
      pts_c = (coin_type == COIN_2X1) ? BASE_PTS_W'(2) : BASE_PTS_W'(1);
    end
  end

endmodule

// File: rtl/score_engine.sv
// Multi-lane score keeper: judges all lanes each tick, accumulates a
// saturating score with a streak multiplier, tracks lives and the high score.
module score_engine
  import coin_game_pkg::*;
#(
  parameter int unsigned N_COINS     = 2,
  parameter int unsigned X_W         = 3,
  parameter int unsigned Y_W         = 4,
  parameter int unsigned CATCH_Y     = CATCH_Y_DEFAULT,
  parameter int unsigned SCORE_W     = 8,
  parameter int unsigned SCORE_MAX   = 99,
  parameter int unsigned LIVES_INIT  = 3,
  parameter int unsigned LIVES_W     = 2,
  parameter int unsigned STREAK_STEP = 4,
  parameter int unsigned MULT_MAX    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic                   start,
  input  logic [X_W-1:0]         player_x,
  input  logic [N_COINS*X_W-1:0] coin_x,
  input  logic [N_COINS*Y_W-1:0] coin_y,
  input  logic [N_COINS-1:0]     coin_type,
  input  logic [N_COINS-1:0]     coin_valid,
  output logic [N_COINS-1:0]     caught,
  output logic [N_COINS-1:0]     missed,
  output logic [SCORE_W-1:0]     score_out,
  output logic [SCORE_W-1:0]     high_score,
  output logic [2:0]             mult,
  output logic [LIVES_W-1:0]     lives,
  output logic                   game_over
);

  localparam int unsigned STREAK_MAX   = STREAK_STEP * (MULT_MAX - 1);
  localparam int unsigned STREAK_W     = $clog2(STREAK_MAX + 1) + 1;
  localparam int unsigned CNT_W        = $clog2(N_COINS + 1);
  localparam int unsigned STREAK_ACC_W = STREAK_W + CNT_W;
  localparam int unsigned MULT_CALC_W  = STREAK_W + 1;
  localparam int unsigned BASE_SUM_W   = $clog2(2 * N_COINS + 1);
  localparam int unsigned PROD_W       = BASE_SUM_W + 3;
  localparam int unsigned ACC_W        = ((SCORE_W > PROD_W) ? SCORE_W : PROD_W) + 1;
  localparam int unsigned LIFE_CMP_W   = (LIVES_W > CNT_W) ? LIVES_W : CNT_W;

  logic [N_COINS-1:0]    lane_hit;
  logic [N_COINS-1:0]    lane_miss;
  logic [BASE_PTS_W-1:0] lane_pts [N_COINS];

  for (genvar g = 0; g < N_COINS; g++) begin : g_lane
    lane_judge #(
      .X_W     (X_W),
      .Y_W     (Y_W),
      .CATCH_Y (CATCH_Y)
    ) u_judge (
      .player_x   (player_x),
      .coin_x     (coin_x[g*X_W +: X_W]),
      .coin_y     (coin_y[g*Y_W +: Y_W]),
      .coin_type  (coin_type[g]),
      .coin_valid (coin_valid[g]),
      .hit_c      (lane_hit[g]),
      .miss_c     (lane_miss[g]),
      .pts_c      (lane_pts[g])
    );
  end

  game_state_t         state_q, state_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [SCORE_W-1:0]  high_q, high_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [2:0]          mult_q, mult_d;
  logic [LIVES_W-1:0]  lives_q, lives_d;
  logic                game_over_q, game_over_d;
  logic [N_COINS-1:0]  caught_q, caught_d;
  logic [N_COINS-1:0]  missed_q, missed_d;

  logic [BASE_SUM_W-1:0]   base_sum;
  logic [CNT_W-1:0]        catch_cnt;
  logic [CNT_W-1:0]        miss_cnt;
  logic [PROD_W-1:0]       points;
  logic [ACC_W-1:0]        score_sum;
  logic [SCORE_W-1:0]      score_new;
  logic [SCORE_W-1:0]      high_new;
  logic [STREAK_ACC_W-1:0] streak_sum;
  logic [STREAK_W-1:0]     streak_new;
  logic [MULT_CALC_W-1:0]  mult_calc;
  logic [2:0]              mult_new;
  logic [LIVES_W-1:0]      lives_new;

  // Adder tree over lanes: base points, catch count and miss count.
  always_comb begin
    base_sum  = '0;
    catch_cnt = '0;
    miss_cnt  = '0;
    for (int i = 0; i < int'(N_COINS); i++) begin
      base_sum  = base_sum + BASE_SUM_W'(lane_pts[i]);
      catch_cnt = catch_cnt + CNT_W'(lane_hit[i]);
      miss_cnt  = miss_cnt + CNT_W'(lane_miss[i]);
    end
  end

  // Tick results: points use the multiplier in force before this tick.
  always_comb begin
    points     = PROD_W'(base_sum) * PROD_W'(mult_q);
    score_sum  = ACC_W'(score_q) + ACC_W'(points);
    score_new  = (score_sum > ACC_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : SCORE_W'(score_sum);
    high_new   = (score_new > high_q) ? score_new : high_q;

    streak_sum = STREAK_ACC_W'(streak_q) + STREAK_ACC_W'(catch_cnt);
    if (miss_cnt != '0) begin
      streak_new = '0;
    end else if (streak_sum > STREAK_ACC_W'(STREAK_MAX)) begin
      streak_new = STREAK_W'(STREAK_MAX);
    end else begin
      streak_new = STREAK_W'(streak_sum);
    end

    mult_calc = MULT_CALC_W'(streak_new / STREAK_W'(STREAK_STEP)) + MULT_CALC_W'(1);
    mult_new  = (mult_calc > MULT_CALC_W'(MULT_MAX)) ? 3'(MULT_MAX) : 3'(mult_calc);

    if (LIFE_CMP_W'(miss_cnt) >= LIFE_CMP_W'(lives_q)) begin
      lives_new = '0;
    end else begin
      lives_new = lives_q - LIVES_W'(miss_cnt);
    end
  end

  // Game FSM and counter updates.
  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    high_d      = high_q;
    streak_d    = streak_q;
    mult_d      = mult_q;
    lives_d     = lives_q;
    game_over_d = game_over_q;
    caught_d    = '0;
    missed_d    = '0;
    unique case (state_q)
      ST_OVER: begin
        if (start) begin
          state_d     = ST_PLAY;
          score_d     = '0;
          streak_d    = '0;
          mult_d      = 3'd1;
          lives_d     = LIVES_W'(LIVES_INIT);
          game_over_d = 1'b0;
        end
      end
      ST_PLAY: begin
        if (tick) begin
          caught_d = lane_hit;
          missed_d = lane_miss;
          score_d  = score_new;
          high_d   = high_new;
          streak_d = streak_new;
          mult_d   = mult_new;
          lives_d  = lives_new;
          if (lives_new == '0) begin
            state_d     = ST_OVER;
            game_over_d = 1'b1;
          end
        end
      end
      default: begin
        state_d     = ST_OVER;
        game_over_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_OVER;
      score_q     <= '0;
      high_q      <= '0;
      streak_q    <= '0;
      mult_q      <= 3'd1;
      lives_q     <= '0;
      game_over_q <= 1'b1;
      caught_q    <= '0;
      missed_q    <= '0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      high_q      <= high_d;
      streak_q    <= streak_d;
      mult_q      <= mult_d;
      lives_q     <= lives_d;
      game_over_q <= game_over_d;
      caught_q    <= caught_d;
      missed_q    <= missed_d;
    end
  end

  assign caught     = caught_q;
  assign missed     = missed_q;
  assign score_out  = score_q;
  assign high_score = high_q;
  assign mult       = mult_q;
  assign lives      = lives_q;
  assign game_over  = game_over_q;

endmodule

// File: tb/tb_score_engine.sv
// Directed bench for score_engine: each step queues its expected outputs,
// clocks once, then pops the entry and compares it against the registered outputs.
module tb_score_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       start;
  logic [2:0] player_x;
  logic [5:0] coin_x;
  logic [7:0] coin_y;
  logic [1:0] coin_type;
  logic [1:0] coin_valid;
  logic [1:0] caught;
  logic [1:0] missed;
  logic [7:0] score_out;
  logic [7:0] high_score;
  logic [2:0] mult;
  logic [1:0] lives;
  logic       game_over;

  always #5 clk = ~clk;

  score_engine dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .start      (start),
    .player_x   (player_x),
    .coin_x     (coin_x),
    .coin_y     (coin_y),
    .coin_type  (coin_type),
    .coin_valid (coin_valid),
    .caught     (caught),
    .missed     (missed),
    .score_out  (score_out),
    .high_score (high_score),
    .mult       (mult),
    .lives      (lives),
    .game_over  (game_over)
  );

  typedef struct {
    int         id;
    logic [1:0] caught;
    logic [1:0] missed;
    logic [7:0] score;
    logic [7:0] high;
    logic [2:0] mult;
    logic [1:0] lives;
    logic       go;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check_field(input string name, input int id,
                             input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step %0d: observed %0d expected %0d", name, id, obs, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic v, input logic t,
                          input logic [2:0] x, input logic [3:0] y);
    coin_valid[i]      = v;
    coin_type[i]       = t;
    coin_x[i*3 +: 3]   = x;
    coin_y[i*4 +: 4]   = y;
  endtask

  task automatic step(input int id, input logic [1:0] c, input logic [1:0] m,
                      input logic [7:0] s, input logic [7:0] h, input logic [2:0] mu,
                      input logic [1:0] l, input logic g);
    exp_t e;
    e.id = id; e.caught = c; e.missed = m; e.score = s; e.high = h;
    e.mult = mu; e.lives = l; e.go = g;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_field("caught",     e.id, 8'(caught),     8'(e.caught));
    check_field("missed",     e.id, 8'(missed),     8'(e.missed));
    check_field("score_out",  e.id, score_out,      e.score);
    check_field("high_score", e.id, high_score,     e.high);
    check_field("mult",       e.id, 8'(mult),       8'(e.mult));
    check_field("lives",      e.id, 8'(lives),      8'(e.lives));
    check_field("game_over",  e.id, 8'(game_over),  8'(e.go));
  endtask

  initial begin
    reset = 1'b1; tick = 1'b1; start = 1'b1; player_x = 3'd4;
    coin_x = '0; coin_y = '0; coin_type = '0; coin_valid = '0;
    // Reset wins over start and tick.
    step(0, 2'b00, 2'b00, 8'd0, 8'd0, 3'd1, 2'd0, 1'b1);
    reset = 1'b0; tick = 1'b0;
    step(1, 2'b00, 2'b00, 8'd0, 8'd0, 3'd1, 2'd3, 1'b0);
    start = 1'b0;

    // Wrong row on lane0, invalid lane1 at the catch row: nothing judged.
    set_lane(0, 1'b1, 1'b0, 3'd4, 4'd14);
    set_lane(1, 1'b0, 1'b0, 3'd4, 4'd15);
    tick = 1'b1;
    step(2, 2'b00, 2'b00, 8'd0, 8'd0, 3'd1, 2'd3, 1'b0);

    set_lane(0, 1'b1, 1'b0, 3'd4, 4'd15);
    step(3, 2'b01, 2'b00, 8'd1, 8'd1, 3'd1, 2'd3, 1'b0);
    tick = 1'b0;
    step(4, 2'b00, 2'b00, 8'd1, 8'd1, 3'd1, 2'd3, 1'b0);
    tick = 1'b1;
    step(5, 2'b01, 2'b00, 8'd2, 8'd2, 3'd1, 2'd3, 1'b0);
    step(6, 2'b01, 2'b00, 8'd3, 8'd3, 3'd1, 2'd3, 1'b0);
    step(7, 2'b01, 2'b00, 8'd4, 8'd4, 3'd2, 2'd3, 1'b0);
    step(8, 2'b01, 2'b00, 8'd6, 8'd6, 3'd2, 2'd3, 1'b0);

    // 2x1 at column 7 does not wrap to column 0.
    set_lane(0, 1'b1, 1'b1, 3'd7, 4'd15);
    player_x = 3'd0;
    step(9, 2'b00, 2'b01, 8'd6, 8'd6, 3'd1, 2'd2, 1'b0);

    set_lane(0, 1'b1, 1'b0, 3'd4, 4'd15);
    set_lane(1, 1'b1, 1'b0, 3'd4, 4'd15);
    player_x = 3'd4;
    step(10, 2'b11, 2'b00, 8'd8,  8'd8,  3'd1, 2'd2, 1'b0);
    step(11, 2'b11, 2'b00, 8'd10, 8'd10, 3'd2, 2'd2, 1'b0);
    step(12, 2'b11, 2'b00, 8'd14, 8'd14, 3'd2, 2'd2, 1'b0);
    step(13, 2'b11, 2'b00, 8'd18, 8'd18, 3'd3, 2'd2, 1'b0);

    // Mixed tick: 2x1 right-half hit at mult 3 (+6), lane1 miss.
    set_lane(0, 1'b1, 1'b1, 3'd3, 4'd15);
    set_lane(1, 1'b1, 1'b0, 3'd1, 4'd15);
    step(14, 2'b01, 2'b10, 8'd24, 8'd24, 3'd1, 2'd1, 1'b0);

    // Climb to the multiplier cap and the score ceiling with two 2x1 coins.
    set_lane(0, 1'b1, 1'b1, 3'd4, 4'd15);
    set_lane(1, 1'b1, 1'b1, 3'd3, 4'd15);
    step(15, 2'b11, 2'b00, 8'd28, 8'd28, 3'd1, 2'd1, 1'b0);
    step(16, 2'b11, 2'b00, 8'd32, 8'd32, 3'd2, 2'd1, 1'b0);
    step(17, 2'b11, 2'b00, 8'd40, 8'd40, 3'd2, 2'd1, 1'b0);
    step(18, 2'b11, 2'b00, 8'd48, 8'd48, 3'd3, 2'd1, 1'b0);
    step(19, 2'b11, 2'b00, 8'd60, 8'd60, 3'd3, 2'd1, 1'b0);
    step(20, 2'b11, 2'b00, 8'd72, 8'd72, 3'd4, 2'd1, 1'b0);
    step(21, 2'b11, 2'b00, 8'd88, 8'd88, 3'd4, 2'd1, 1'b0);
    step(22, 2'b11, 2'b00, 8'd99, 8'd99, 3'd4, 2'd1, 1'b0);
    step(23, 2'b11, 2'b00, 8'd99, 8'd99, 3'd4, 2'd1, 1'b0);

    // Fatal miss on the last life.
    set_lane(0, 1'b1, 1'b0, 3'd0, 4'd15);
    set_lane(1, 1'b0, 1'b0, 3'd0, 4'd0);
    step(24, 2'b00, 2'b01, 8'd99, 8'd99, 3'd1, 2'd0, 1'b1);

    set_lane(0, 1'b1, 1'b0, 3'd4, 4'd15);
    step(25, 2'b00, 2'b00, 8'd99, 8'd99, 3'd1, 2'd0, 1'b1);

    // Restart keeps the high score; lanes are not judged on the start clk.
    start = 1'b1;
    step(26, 2'b00, 2'b00, 8'd0, 8'd99, 3'd1, 2'd3, 1'b0);
    step(27, 2'b01, 2'b00, 8'd1, 8'd99, 3'd1, 2'd3, 1'b0);

    start = 1'b0; tick = 1'b0; reset = 1'b1;
    step(28, 2'b00, 2'b00, 8'd0, 8'd0, 3'd1, 2'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
